// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: RS-232 style asynchronous receiver feeding a small receive FIFO.
//
// The serial line is synchronised, each frame is sampled at mid-bit using a
// down-counting baud counter, and every completed frame is pushed into the FIFO
// together with its parity-error and framing-error flags.
//
// Ports:
//   clk         single clock, all flops on the rising edge
//   rst         asynchronous active-high reset
//   rx          asynchronous serial input, idles high
//   dout        data of the word at the FIFO head (0 while empty)
//   dout_perr   parity-error flag of the head word
//   dout_ferr   framing-error flag of the head word
//   dout_valid  FIFO holds at least one word
//   dout_ready  consumer accepts the head word (pop on dout_valid & dout_ready)
//   overrun     sticky, a received word was dropped because the FIFO was full
//   clr_ovr     synchronous clear of overrun (a simultaneous drop wins)
//   count       FIFO occupancy
//   busy        receiver is inside a frame (FSM not idle)
module rs232_rx_fifo #(
    parameter logic [19:0] RS232_RATIO = 20'd1736,
    parameter int          DATA_W      = 8,
    parameter int          PARITY_MODE = 1,
    parameter int          STOP_BITS   = 1,
    parameter int          MSB_FIRST   = 1,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [DATA_W-1:0]           dout,
    output logic                        dout_perr,
    output logic                        dout_ferr,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        overrun,
    input  logic                        clr_ovr,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        busy
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              EW        = DATA_W + 2;
    localparam int              LB        = DATA_W - 1;
    localparam logic [3:0]      LAST_BIT  = LB[3:0];
    localparam logic            LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [19:0]     HALF      = RS232_RATIO >> 1;
    localparam logic [19:0]     RELOAD    = RS232_RATIO - 20'd1;
    localparam logic [AW:0]     FULL_CNT  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]     CNT_ONE   = 1;
    localparam logic [AW-1:0]   PTR_ONE   = 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t            state, state_n;
    logic              rx_meta, rxs;
    logic [19:0]       baud_cnt, baud_n;
    logic [3:0]        bit_cnt, bit_n;
    logic [DATA_W-1:0] data_reg, data_n;
    logic              perr_reg, perr_n;
    logic              ferr_reg, ferr_n;
    logic              stop_cnt, stop_n;
    logic              strobe;
    logic              push;
    logic [EW-1:0]     push_word;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [EW-1:0]     head;
    logic              do_push, do_pop, drop;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_reg <= '0;
            perr_reg <= 1'b0;
            ferr_reg <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            data_reg <= data_n;
            perr_reg <= perr_n;
            ferr_reg <= ferr_n;
            stop_cnt <= stop_n;
        end
    end

    // Frame sequencing. The half-bit load on the falling edge puts every
    // later strobe near the middle of its bit. BREAK absorbs a line held low
    // after a bad stop bit so it produces a single word, not a stream.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        data_n  = data_reg;
        perr_n  = perr_reg;
        ferr_n  = ferr_reg;
        stop_n  = stop_cnt;
        push    = 1'b0;
        strobe  = (baud_cnt == 20'd0);

        if (state != IDLE && state != BREAK) begin
            baud_n = strobe ? RELOAD : baud_cnt - 20'd1;
        end

        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    baud_n  = HALF;
                end
            end
            START: begin
                if (strobe) begin
                    if (!rxs) begin
                        state_n = DATA;
                        bit_n   = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
                        stop_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    data_n = (MSB_FIRST != 0) ? {data_reg[DATA_W-2:0], rxs}
                                              : {rxs, data_reg[DATA_W-1:1]};
                    bit_n  = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    perr_n  = (((^data_reg) ^ rxs) != (PARITY_MODE == 1));
                    state_n = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    ferr_n = ferr_reg | ~rxs;
                    if (stop_cnt == LAST_STOP) begin
                        push    = 1'b1;
                        state_n = rxs ? IDLE : BREAK;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign push_word = {ferr_n, perr_reg, data_reg};
    assign busy      = (state != IDLE);

    // A push into a full FIFO still succeeds when the head is popped in the
    // same cycle; only a push with no room and no pop is dropped.
    assign do_pop  = dout_valid & dout_ready;
    assign do_push = push & ((count != FULL_CNT) | do_pop);
    assign drop    = push & (count == FULL_CNT) & ~do_pop;

    // Storage array, written only; the head is read combinationally.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers, occupancy and the sticky overrun flag (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero while empty so they read 0 out of reset
    // without needing to clear the storage array.
    assign dout_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign dout       = dout_valid ? head[DATA_W-1:0] : '0;
    assign dout_perr  = dout_valid ? head[DATA_W]     : 1'b0;
    assign dout_ferr  = dout_valid ? head[DATA_W+1]   : 1'b0;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo: self-checking bench for rs232_rx_fifo.
//
// Main instance: 16 clocks/bit, 8 data bits, odd parity, 1 stop, MSB first,
// 4-entry FIFO. Second instance: LSB first, 2 stop bits, no parity.
// Frames are serialised by the bench from hand-written data values and the
// received words are compared against constant expectations.
module tb_rs232_rx_fifo;
    localparam int RATIO = 16;

    typedef struct {
        logic [7:0] data;
        logic       flip_par;
        logic       stop_val;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx2;
    logic [7:0] dout, dout2;
    logic       dout_perr, dout_ferr, dout_valid, dout_ready;
    logic       perr2, ferr2, valid2, ready2;
    logic       overrun, clr_ovr, ovr2, clr2;
    logic [2:0] count, count2;
    logic       busy, busy2;

    int         total = 0;
    int         bad   = 0;
    vec_t       vecs [7];
    logic [7:0] fill_words [5];
    logic [7:0] drain_words [4];

    always #5 clk = ~clk;

    rs232_rx_fifo #(
        .RS232_RATIO(20'd16), .DATA_W(8), .PARITY_MODE(1),
        .STOP_BITS(1), .MSB_FIRST(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .dout(dout), .dout_perr(dout_perr), .dout_ferr(dout_ferr),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .clr_ovr(clr_ovr), .count(count), .busy(busy)
    );

    rs232_rx_fifo #(
        .RS232_RATIO(20'd16), .DATA_W(8), .PARITY_MODE(0),
        .STOP_BITS(2), .MSB_FIRST(0), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .rst(rst), .rx(rx2),
        .dout(dout2), .dout_perr(perr2), .dout_ferr(ferr2),
        .dout_valid(valid2), .dout_ready(ready2),
        .overrun(ovr2), .clr_ovr(clr2), .count(count2), .busy(busy2)
    );

    // One comparison; every check in the bench goes through here.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold one bit on the selected line for a full bit time.
    task automatic drive_bit(input bit second, input logic b);
        if (second) rx2 = b;
        else        rx  = b;
        repeat (RATIO) @(negedge clk);
    endtask

    // Serialise one frame; the line is left at the last stop-bit level.
    task automatic send_frame(input bit second, input logic [7:0] d,
                              input int pmode, input bit msb, input int nstop,
                              input logic flip, input logic stop_val);
        logic p;
        drive_bit(second, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(second, msb ? d[7-i] : d[i]);
        end
        if (pmode != 0) begin
            p = (pmode == 1) ? ~(^d) : (^d);
            drive_bit(second, p ^ flip);
        end
        for (int s = 0; s < nstop; s++) begin
            drive_bit(second, stop_val);
        end
    endtask

    // Frame on the main instance followed by one idle bit time.
    task automatic apply_stimulus(input vec_t v);
        send_frame(1'b0, v.data, 1, 1'b1, 1, v.flip_par, v.stop_val);
        rx = 1'b1;
        repeat (RATIO) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input bit second);
        int n;
        n = 0;
        while (((second ? valid2 : dout_valid) !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_valid"}, 32'(second ? valid2 : dout_valid), 1);
    endtask

    task automatic pop_one(input bit second);
        if (second) ready2 = 1'b1;
        else        dout_ready = 1'b1;
        @(negedge clk);
        ready2     = 1'b0;
        dout_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; rx2 = 1'b1;
        dout_ready = 1'b0; ready2 = 1'b0; clr_ovr = 1'b0; clr2 = 1'b0;

        vecs[0] = '{8'hF1, 1'b0, 1'b1, 8'hF1, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
        fill_words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drain_words = '{8'h22, 8'h33, 8'h44, 8'h66};

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_valid", 32'(dout_valid), 0);
        check_output("rst_count", 32'(count), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_overrun", 32'(overrun), 0);
        check_output("rst_dout", 32'(dout), 0);
        check_output("rst_perr", 32'(dout_perr), 0);
        check_output("rst_ferr", 32'(dout_ferr), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Push-to-valid latency: stop strobe 172 edges after the falling edge
        fork
            send_frame(1'b0, 8'hF1, 1, 1'b1, 1, 1'b0, 1'b1);
            begin
                repeat (171) @(posedge clk);
                @(negedge clk);
                check_output("lat_before", 32'(dout_valid), 0);
                check_output("lat_busy", 32'(busy), 1);
                @(posedge clk);
                @(negedge clk);
                check_output("lat_after", 32'(dout_valid), 1);
                check_output("lat_count", 32'(count), 1);
            end
        join
        check_output("lat_dout", 32'(dout), 32'h F1);
        check_output("lat_perr", 32'(dout_perr), 0);
        pop_one(1'b0);
        check_output("lat_popped", 32'(count), 0);

        // Table of single frames
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            wait_valid($sformatf("vec%0d", i), 1'b0);
            check_output($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check_output($sformatf("vec%0d_perr", i), 32'(dout_perr), 32'(vecs[i].exp_perr));
            check_output($sformatf("vec%0d_ferr", i), 32'(dout_ferr), 32'(vecs[i].exp_ferr));
            check_output($sformatf("vec%0d_count", i), 32'(count), 1);
            pop_one(1'b0);
            check_output($sformatf("vec%0d_pop", i), 32'(count), 0);
        end

        // Bad stop bit then line held low: one word, busy until release
        send_frame(1'b0, 8'h8A, 1, 1'b1, 1, 1'b0, 1'b0);
        repeat (5 * RATIO) @(negedge clk);
        check_output("brk_busy", 32'(busy), 1);
        check_output("brk_count", 32'(count), 1);
        check_output("brk_dout", 32'(dout), 32'h8A);
        check_output("brk_ferr", 32'(dout_ferr), 1);
        check_output("brk_perr", 32'(dout_perr), 0);
        rx = 1'b1;
        repeat (RATIO) @(negedge clk);
        check_output("brk_idle", 32'(busy), 0);
        check_output("brk_count2", 32'(count), 1);
        pop_one(1'b0);

        // False start: 4-clock low glitch
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check_output("fs_busy", 32'(busy), 1);
        repeat (2 * RATIO) @(negedge clk);
        check_output("fs_idle", 32'(busy), 0);
        check_output("fs_count", 32'(count), 0);

        // Overrun: five words into a 4-entry FIFO
        for (int i = 0; i < 5; i++) begin
            send_frame(1'b0, fill_words[i], 1, 1'b1, 1, 1'b0, 1'b1);
            repeat (RATIO) @(negedge clk);
        end
        check_output("ovr_count", 32'(count), 4);
        check_output("ovr_flag", 32'(overrun), 1);
        check_output("ovr_head", 32'(dout), 32'h11);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check_output("ovr_clr", 32'(overrun), 0);

        // Pop exactly in the push cycle while full
        fork
            send_frame(1'b0, 8'h66, 1, 1'b1, 1, 1'b0, 1'b1);
            begin
                repeat (171) @(posedge clk);
                @(negedge clk);
                dout_ready = 1'b1;
                @(negedge clk);
                dout_ready = 1'b0;
            end
        join
        repeat (RATIO) @(negedge clk);
        check_output("pp_count", 32'(count), 4);
        check_output("pp_ovr", 32'(overrun), 0);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("drain%0d", i), 32'(dout), 32'(drain_words[i]));
            pop_one(1'b0);
        end
        check_output("drain_count", 32'(count), 0);
        pop_one(1'b0);
        check_output("empty_pop_count", 32'(count), 0);
        check_output("empty_pop_valid", 32'(dout_valid), 0);

        // Reset mid-frame with a word already queued
        send_frame(1'b0, 8'h77, 1, 1'b1, 1, 1'b0, 1'b1);
        repeat (RATIO) @(negedge clk);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check_output("mid_rst_busy", 32'(busy), 0);
        check_output("mid_rst_count", 32'(count), 0);
        check_output("mid_rst_valid", 32'(dout_valid), 0);
        check_output("mid_rst_dout", 32'(dout), 0);
        rst = 1'b0;
        repeat (2 * RATIO) @(negedge clk);
        check_output("post_rst_busy", 32'(busy), 0);
        check_output("post_rst_count", 32'(count), 0);
        send_frame(1'b0, 8'h34, 1, 1'b1, 1, 1'b0, 1'b1);
        repeat (RATIO) @(negedge clk);
        wait_valid("post_rst", 1'b0);
        check_output("post_rst_dout", 32'(dout), 32'h34);
        check_output("post_rst_count1", 32'(count), 1);
        pop_one(1'b0);

        // LSB first, two stop bits, no parity
        send_frame(1'b1, 8'h12, 0, 1'b0, 2, 1'b0, 1'b1);
        repeat (RATIO) @(negedge clk);
        wait_valid("lsb", 1'b1);
        check_output("lsb_dout", 32'(dout2), 32'h12);
        check_output("lsb_perr", 32'(perr2), 0);
        check_output("lsb_ferr", 32'(ferr2), 0);
        check_output("lsb_count", 32'(count2), 1);
        send_frame(1'b1, 8'hC3, 0, 1'b0, 2, 1'b0, 1'b1);
        repeat (RATIO) @(negedge clk);
        check_output("lsb_count2", 32'(count2), 2);
        check_output("lsb_hold", 32'(dout2), 32'h12);
        pop_one(1'b1);
        check_output("lsb_dout2", 32'(dout2), 32'hC3);
        check_output("lsb_ovr", 32'(ovr2), 0);
        check_output("lsb_busy", 32'(busy2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs232_rx_fifo.md
RS232_RX_FIFO -- requirements
Module: rs232_rx_fifo

Interface
REQ-001 Parameter RS232_RATIO, 20'd1736, clk cycles per bit; legal range 4..1048575.
REQ-002 Parameter DATA_W, 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, 1, parity setting: 0 none, 1 odd (data+parity XOR = 1), 2 even.
REQ-004 Parameter STOP_BITS, 1, number of stop bits; legal values 1 or 2.
REQ-005 Parameter MSB_FIRST, 1, bit order: 1 first data bit is MSB, 0 first data bit is LSB.
REQ-006 Parameter FIFO_DEPTH, 8, receive FIFO entries; power of 2, range 2..256.
REQ-007 Port clk, input, 1, single clock; all flops rise on posedge.
REQ-008 Port rst, input, 1, asynchronous active-high reset.
REQ-009 Port rx, input, 1, asynchronous serial line; idles high.
REQ-010 Port dout, output, DATA_W, FIFO head data.
REQ-011 Port dout_perr, output, 1, parity-error flag of head word.
REQ-012 Port dout_ferr, output, 1, framing-error flag of head word.
REQ-013 Port dout_valid, output, 1, FIFO non-empty.
REQ-014 Port dout_ready, input, 1, consumer accept; pop on dout_valid & dout_ready.
REQ-015 Port overrun, output, 1, sticky: a word was dropped because the FIFO was full.
REQ-016 Port clr_ovr, input, 1, synchronous clear of overrun.
REQ-017 Port count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-018 Port busy, output, 1, FSM is not in IDLE.

Function
REQ-019 rx SHALL pass through a 2-flop synchroniser reset to 1; all logic uses the synchronised value rxs.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 IDLE: when rxs is 0, load the baud counter with RS232_RATIO/2 and go to START.
REQ-022 The baud counter SHALL count down; the sample strobe fires when it reaches 0, then it reloads RS232_RATIO-1.
REQ-023 START strobe: if rxs is 0, go to DATA with bit counter 0; if rxs is 1, treat as a false start and return to IDLE with no push.
REQ-024 DATA: each strobe shifts rxs into the data register per MSB_FIRST. After DATA_W bits, go to PARITY if PARITY_MODE is not 0, else go to STOP.
REQ-025 PARITY strobe: perr = (^data ^ rxs) != (PARITY_MODE==1); this check applies for PARITY_MODE 1 and 2, and perr is 0 when PARITY_MODE is 0.
REQ-026 STOP: sample STOP_BITS strobes; ferr = 1 if any stop sample is 0. The last stop strobe SHALL push {ferr, perr, data} in that same cycle.
REQ-027 After the push: if the last stop sample was 0, go to BREAK; otherwise go to IDLE.
REQ-028 BREAK SHALL stay until rxs is 1, then go to IDLE, so a held-low line yields exactly one word.
REQ-029 Push-to-dout_valid latency SHALL be 1 clk; there is no bypass from push to dout.
REQ-030 Push while count==FIFO_DEPTH with no pop: drop the word and set overrun in the next cycle.
REQ-031 Push and pop in the same cycle SHALL both succeed at any occupancy, including full; count is unchanged and overrun is not set.
REQ-032 Pop while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-033 When clr_ovr and a drop occur in the same cycle, overrun SHALL be set (set wins).
REQ-034 dout, dout_perr and dout_ferr SHALL hold stable while dout_valid=1 and dout_ready=0.

Reset
REQ-035 Reset SHALL set: FSM to IDLE; counters to 0; FIFO empty; dout_valid=0; overrun=0; busy=0; count=0; dout, dout_perr, dout_ferr=0; synchroniser flops=1.
REQ-036 Reset mid-frame SHALL abort the frame with no push; after release, the FSM waits in IDLE for a new falling edge.

Verification (RS232_RATIO=16, DATA_W=8, PARITY_MODE=1, STOP_BITS=1, MSB_FIRST=1, FIFO_DEPTH=4 unless stated)
REQ-037 Send 8'hF1 with odd parity, MSB first -> dout=8'hF1, perr=0, ferr=0; dout_valid rises 1 clk after the push.
REQ-038 Send 8'h0F with inverted parity bit -> dout=8'h0F, dout_perr=1, dout_ferr=0.
REQ-039 Send 8'h8A with stop bit 0, then hold rx low for 5 bit times -> exactly one word pushed with ferr=1; busy stays 1 until rx returns high.
REQ-040 Send 5 words with dout_ready=0 -> count=4, overrun=1, head=first word. Then pulse clr_ovr -> overrun=0. Then pop with a concurrent push -> count stays 4.
REQ-041 Pulse rx low for 4 clk -> false start; no push; busy returns to 0.
REQ-042 Assert rst during the DATA state of 8'h5A, then send 8'h34 -> only 8'h34 is received. Rerun with MSB_FIRST=0, STOP_BITS=2, PARITY_MODE=0 and send 8'h12 -> dout=8'h12.
